// File: rtl/assoc_buffer_arbiter_if.sv
// Requester-side bus of the associative buffer arbiter: packed per-requester
// request fields in, one-hot completion and lookup response out.
interface assoc_buffer_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int KEY_WIDTH  = 5,
   parameter int DATA_WIDTH = 8,
   parameter int CTRL_WIDTH = 2
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*CTRL_WIDTH-1:0] req_op;
   logic [NUM_REQ*KEY_WIDTH-1:0]  req_key;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            done;
   logic [DATA_WIDTH-1:0]         rsp_data;
   logic                          rsp_hit;

   modport master (
      output req, req_op, req_key, req_data,
      input  done, rsp_data, rsp_hit
   );

   modport slave (
      input  req, req_op, req_key, req_data,
      output done, rsp_data, rsp_hit
   );
endinterface

// File: rtl/assoc_buffer_arbiter.sv
// Round-robin arbiter letting NUM_REQ requesters share one associative buffer,
// one transaction in flight at a time (grant, issue, capture).
//
// state   | meaning
// IDLE    | no transaction; arbitrate, done pulses here after a capture
// ISSUE   | latched op/key/data driven to the buffer for one cycle
// CAPTURE | buffer registered output sampled into rsp_data/rsp_hit
module assoc_buffer_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int KEY_WIDTH  = 5,
   parameter int DATA_WIDTH = 8,
   parameter int CTRL_WIDTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   assoc_buffer_arbiter_if.slave    bus,
   output logic                     busy,
   output logic [CTRL_WIDTH-1:0]    buf_ctrl,
   output logic [KEY_WIDTH-1:0]     buf_key,
   output logic [DATA_WIDTH-1:0]    buf_data,
   input  logic [DATA_WIDTH-1:0]    buf_data_out,
   input  logic                     buf_valid
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CTRL_WIDTH-1:0] OP_NONE = '0;
   localparam logic [NUM_REQ-1:0]    ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t                 state;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       winner;
   logic [NUM_REQ-1:0]     done_q;
   logic [DATA_WIDTH-1:0]  rsp_data_q;
   logic                   rsp_hit_q;

   logic [CTRL_WIDTH-1:0]  op_arr   [NUM_REQ];
   logic [KEY_WIDTH-1:0]   key_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];

   logic                   grant_any;
   logic [PTR_W-1:0]       grant_idx;
   logic [PTR_W-1:0]       next_ptr;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign op_arr[g]   = bus.req_op[g*CTRL_WIDTH +: CTRL_WIDTH];
      assign key_arr[g]  = bus.req_key[g*KEY_WIDTH +: KEY_WIDTH];
      assign data_arr[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Scan from rr_ptr upward with wrap; the first requester found wins.
   always_comb begin
      int               sum;
      logic [PTR_W-1:0] cand;
      grant_any = 1'b0;
      grant_idx = '0;
      sum       = 0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = int'(rr_ptr) + i;
         if (sum >= NUM_REQ) sum = sum - NUM_REQ;
         cand = PTR_W'(sum);
         if (!grant_any && bus.req[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         winner     <= '0;
         done_q     <= '0;
         rsp_data_q <= '0;
         rsp_hit_q  <= 1'b0;
         busy       <= 1'b0;
         buf_ctrl   <= OP_NONE;
         buf_key    <= '0;
         buf_data   <= '0;
      end else begin
         done_q <= '0;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  state    <= ISSUE;
                  winner   <= grant_idx;
                  rr_ptr   <= next_ptr;
                  buf_ctrl <= op_arr[grant_idx];
                  buf_key  <= key_arr[grant_idx];
                  buf_data <= data_arr[grant_idx];
                  busy     <= 1'b1;
               end
            end
            ISSUE: begin
               state    <= CAPTURE;
               buf_ctrl <= OP_NONE;
            end
            CAPTURE: begin
               // Buffer output now reflects the key presented during ISSUE.
               state      <= IDLE;
               rsp_data_q <= buf_data_out;
               rsp_hit_q  <= buf_valid;
               done_q     <= ONE_HOT0 << winner;
               busy       <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               buf_ctrl <= OP_NONE;
            end
         endcase
      end
   end

   assign bus.done     = done_q;
   assign bus.rsp_data = rsp_data_q;
   assign bus.rsp_hit  = rsp_hit_q;

endmodule

// File: tb/tb_assoc_buffer_arbiter.sv
// Directed bench for assoc_buffer_arbiter with a behavioural associative
// buffer and an in-order scoreboard of expected completions.
module tb_assoc_buffer_arbiter;

   localparam int NR = 4;
   localparam int KW = 5;
   localparam int DW = 8;
   localparam int CW = 2;
   localparam logic [1:0] OP_NONE = 2'd0;
   localparam logic [1:0] OP_CLR  = 2'd1;
   localparam logic [1:0] OP_LOAD = 2'd2;
   localparam logic [1:0] OP_INCR = 2'd3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          busy;
   logic [CW-1:0] buf_ctrl;
   logic [KW-1:0] buf_key;
   logic [DW-1:0] buf_data;
   logic [DW-1:0] buf_data_out = '0;
   logic          buf_valid = 1'b0;

   assoc_buffer_arbiter_if #(.NUM_REQ(NR), .KEY_WIDTH(KW), .DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

   assoc_buffer_arbiter #(.NUM_REQ(NR), .KEY_WIDTH(KW), .DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .busy         (busy),
      .buf_ctrl     (buf_ctrl),
      .buf_key      (buf_key),
      .buf_data     (buf_data),
      .buf_data_out (buf_data_out),
      .buf_valid    (buf_valid)
   );

   always #5 clk = ~clk;

   // External buffer: registered read of the presented key, op applied after.
   logic [DW-1:0] bmem [32] = '{default: '0};
   logic          bvld [32] = '{default: 1'b0};
   int            issue_cnt = 0;
   int            incr_cnt  = 0;
   logic          incr_b2b  = 1'b0;
   logic [CW-1:0] prev_ctrl = '0;

   always @(posedge clk) begin
      buf_data_out <= bmem[buf_key];
      buf_valid    <= bvld[buf_key];
      case (buf_ctrl)
         OP_CLR:  begin bmem[buf_key] <= '0;                 bvld[buf_key] <= 1'b0; end
         OP_LOAD: begin bmem[buf_key] <= buf_data;           bvld[buf_key] <= 1'b1; end
         OP_INCR: begin bmem[buf_key] <= bmem[buf_key] + 1'b1; bvld[buf_key] <= 1'b1; end
         default: ;
      endcase
      if (buf_ctrl != OP_NONE) issue_cnt <= issue_cnt + 1;
      if (buf_ctrl == OP_INCR) begin
         incr_cnt <= incr_cnt + 1;
         if (prev_ctrl == OP_INCR) incr_b2b <= 1'b1;
      end
      prev_ctrl <= buf_ctrl;
   end

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
      logic          hit;
   } exp_t;

   exp_t          exp_q [$];
   logic [DW-1:0] ref_mem [32];
   logic          ref_vld [32];
   int            vectors = 0;
   int            miscompares = 0;
   logic [NR-1:0] prev_done = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected response is the buffer state seen before this op is applied.
   task automatic push_exp(input int idx, input logic [1:0] op, input logic [4:0] key, input logic [7:0] data);
      exp_t e;
      e.idx  = idx;
      e.data = ref_mem[key];
      e.hit  = ref_vld[key];
      exp_q.push_back(e);
      case (op)
         OP_CLR:  begin ref_mem[key] = '0;                  ref_vld[key] = 1'b0; end
         OP_LOAD: begin ref_mem[key] = data;                ref_vld[key] = 1'b1; end
         OP_INCR: begin ref_mem[key] = ref_mem[key] + 1'b1; ref_vld[key] = 1'b1; end
         default: ;
      endcase
   endtask

   task automatic set_fields(input int i, input logic [1:0] op, input logic [4:0] key, input logic [7:0] data);
      bus.req_op[i*CW +: CW]   = op;
      bus.req_key[i*KW +: KW]  = key;
      bus.req_data[i*DW +: DW] = data;
   endtask

   task automatic check_done();
      exp_t e;
      chk("done_gap", 32'(prev_done), 32'd0);
      if (exp_q.size() == 0) begin
         chk("done_unexpected", 32'(bus.done), 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("done_vec", 32'(bus.done), 32'(1) << e.idx);
         chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
         chk("rsp_hit", 32'(bus.rsp_hit), 32'(e.hit));
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (rst && bus.done != '0) check_done();
      prev_done = bus.done;
   endtask

   task automatic single(input int idx, input logic [1:0] op, input logic [4:0] key, input logic [7:0] data);
      set_fields(idx, op, key, data);
      push_exp(idx, op, key, data);
      bus.req[idx] = 1'b1;
      tick();
      chk("issue_busy", 32'(busy), 32'd1);
      chk("issue_ctrl", 32'(buf_ctrl), 32'(op));
      chk("issue_key", 32'(buf_key), 32'(key));
      chk("issue_data", 32'(buf_data), 32'(data));
      tick();
      chk("capture_ctrl", 32'(buf_ctrl), 32'(OP_NONE));
      chk("capture_key", 32'(buf_key), 32'(key));
      chk("capture_done", 32'(bus.done), 32'd0);
      tick();
      chk("single_done", 32'(bus.done), 32'(1) << idx);
      chk("single_idle", 32'(busy), 32'd0);
      bus.req[idx] = 1'b0;
   endtask

   // Hold every requester with a nonzero count until it has been served that many times.
   task automatic multi(input int r0, input int r1, input int r2, input int r3);
      int rem [NR];
      int total;
      int served;
      rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
      total  = r0 + r1 + r2 + r3;
      served = 0;
      for (int i = 0; i < NR; i++) bus.req[i] = (rem[i] > 0);
      for (int c = 0; c < total * 3 + 20 && served < total; c++) begin
         tick();
         for (int i = 0; i < NR; i++) begin
            if (bus.done[i]) begin
               served++;
               rem[i]--;
               if (rem[i] <= 0) bus.req[i] = 1'b0;
            end
         end
      end
      chk("multi_served", 32'(served), 32'(total));
      bus.req = '0;
   endtask

   initial begin
      int ic;
      int inc0;
      for (int k = 0; k < 32; k++) begin ref_mem[k] = '0; ref_vld[k] = 1'b0; end
      bus.req = '0; bus.req_op = '0; bus.req_key = '0; bus.req_data = '0;

      // Reset state
      tick(); tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ctrl", 32'(buf_ctrl), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_rsp", 32'(bus.rsp_data), 32'd0);
      rst = 1'b1;
      tick();

      // Load then lookup key 5
      single(0, OP_LOAD, 5'd5, 8'h2A);
      single(0, OP_NONE, 5'd5, 8'h00);
      tick(); tick(); tick();
      chk("hold_data", 32'(bus.rsp_data), 32'h2A);
      chk("hold_hit", 32'(bus.rsp_hit), 32'd1);

      // Move rr_ptr to 2, then 0 and 1 together: 0 wins first
      single(1, OP_LOAD, 5'd7, 8'h11);
      set_fields(0, OP_NONE, 5'd7, 8'h00);
      set_fields(1, OP_CLR, 5'd7, 8'h00);
      push_exp(0, OP_NONE, 5'd7, 8'h00);
      push_exp(1, OP_CLR, 5'd7, 8'h00);
      multi(1, 1, 0, 0);
      single(1, OP_NONE, 5'd7, 8'h00);

      // Requester 1 drops and scrambles its fields during ISSUE
      set_fields(1, OP_LOAD, 5'd9, 8'h5C);
      push_exp(1, OP_LOAD, 5'd9, 8'h5C);
      ic = issue_cnt;
      bus.req[1] = 1'b1;
      tick();
      chk("drop_ctrl", 32'(buf_ctrl), 32'(OP_LOAD));
      bus.req[1] = 1'b0;
      set_fields(1, OP_CLR, 5'd0, 8'h00);
      tick(); tick();
      chk("drop_done", 32'(bus.done), 32'b0010);
      chk("drop_issue_once", 32'(issue_cnt - ic), 32'd1);
      single(1, OP_NONE, 5'd9, 8'h00);

      // Two INCRs on key 3 from requesters 0 and 2; rr_ptr is 2 so 2 goes first
      inc0 = incr_cnt;
      set_fields(0, OP_INCR, 5'd3, 8'h00);
      set_fields(2, OP_INCR, 5'd3, 8'h00);
      push_exp(2, OP_INCR, 5'd3, 8'h00);
      push_exp(0, OP_INCR, 5'd3, 8'h00);
      multi(1, 0, 1, 0);
      chk("incr_count", 32'(incr_cnt - inc0), 32'd2);
      chk("incr_overlap", 32'(incr_b2b), 32'd0);

      // Reset during CAPTURE aborts without done
      set_fields(3, OP_NONE, 5'd5, 8'h00);
      push_exp(3, OP_NONE, 5'd5, 8'h00);
      bus.req[3] = 1'b1;
      tick(); tick();
      chk("abort_busy_pre", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      void'(exp_q.pop_back());
      bus.req = '0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ctrl", 32'(buf_ctrl), 32'd0);
      chk("abort_key", 32'(buf_key), 32'd0);
      chk("abort_data", 32'(buf_data), 32'd0);
      chk("abort_rsp", 32'(bus.rsp_data), 32'd0);
      chk("abort_hit", 32'(bus.rsp_hit), 32'd0);
      tick();
      chk("abort_no_done", 32'(bus.done), 32'd0);
      tick();
      chk("abort_no_done2", 32'(bus.done), 32'd0);
      rst = 1'b1;

      // All requesters held: grants rotate 0,1,2,3,0,1,2,3
      for (int i = 0; i < NR; i++) set_fields(i, OP_INCR, 5'(10 + i), 8'h00);
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NR; i++) push_exp(i, OP_INCR, 5'(10 + i), 8'h00);
      multi(2, 2, 2, 2);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      tick(); tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/assoc_buffer_arbiter.md
ASSOC_BUFFER_ARBITER -- requirements
Module: assoc_buffer_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one associative buffer.
REQ-002 Parameter KEY_WIDTH, default 5: key width.
REQ-003 Parameter DATA_WIDTH, default 8: data width.
REQ-004 Parameter CTRL_WIDTH, default 2: op width; encodings NONE=0, CLR=1, LOAD=2, INCR=3.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 req  input  NUM_REQ  per-requester request, held high until matching done.
REQ-008 req_op  input  NUM_REQ*CTRL_WIDTH  per-requester op, slice i at [i*CTRL_WIDTH +: CTRL_WIDTH].
REQ-009 req_key  input  NUM_REQ*KEY_WIDTH  per-requester key, sliced likewise.
REQ-010 req_data  input  NUM_REQ*DATA_WIDTH  per-requester write data, sliced likewise.
REQ-011 done  output  NUM_REQ  one-cycle completion pulse to the served requester.
REQ-012 rsp_data  output  DATA_WIDTH  lookup data returned with done.
REQ-013 rsp_hit  output  1  buffer valid flag returned with done.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 buf_ctrl  output  CTRL_WIDTH  op to buffer.
REQ-016 buf_key  output  KEY_WIDTH  key to buffer.
REQ-017 buf_data  output  DATA_WIDTH  write data to buffer.
REQ-018 buf_data_out  input  DATA_WIDTH  buffer registered data output (one-cycle latency).
REQ-019 buf_valid  input  1  buffer registered valid output.

Function
REQ-020 FSM states IDLE, ISSUE, CAPTURE; exactly one transaction in flight.
REQ-021 IDLE: if any req bit high, select winner by round-robin starting at index rr_ptr, wrapping NUM_REQ-1 -> 0; latch winner index, op, key, data; go ISSUE; else stay IDLE.
REQ-022 On grant, rr_ptr SHALL become (winner+1) mod NUM_REQ.
REQ-023 ISSUE: buf_ctrl = latched op, buf_key = latched key, buf_data = latched data for exactly one cycle; go CAPTURE.
REQ-024 CAPTURE: buf_ctrl = NONE, buf_key held at latched key; register buf_data_out into rsp_data, buf_valid into rsp_hit; assert done[winner] for one cycle in the following IDLE cycle; go IDLE.
REQ-025 In IDLE, buf_ctrl = NONE, buf_key and buf_data = last latched values.
REQ-026 Transaction latency: req sampled at edge N -> done high in cycle after edge N+2; max throughput one transaction per 3 cycles.
REQ-027 rsp_data and rsp_hit SHALL hold their values until the next capture.
REQ-028 req deasserted or fields changed after grant: in-flight transaction completes with latched values; done still pulses.
REQ-029 Requester still high in the done cycle: treated as a new request, arbitrated against others with updated rr_ptr.
REQ-030 All requesters high continuously: grants rotate 0,1,2,3,0,... with no starvation; each requester served at least once per NUM_REQ transactions.
REQ-031 done SHALL never be asserted on more than one bit, nor two consecutive cycles.

Reset
REQ-032 rst low at any time, including mid-transaction: state -> IDLE, rr_ptr = 0, done = 0, rsp_data = 0, rsp_hit = 0, busy = 0, buf_ctrl = NONE, buf_key = 0, buf_data = 0; in-flight transaction aborted without done.
REQ-033 First arbitration after reset SHALL favour requester 0.

Verification
REQ-034 After reset, req=0001, op=LOAD, key=5, data=0x2A -> buf_ctrl=LOAD one cycle, done=0001 three cycles after request, rsp_hit=0; follow-up LOOKUP(op NONE) key=5 -> rsp_data=0x2A, rsp_hit=1.
REQ-035 req=1111 held for 8 transactions -> done order 0,1,2,3,0,1,2,3.
REQ-036 rr_ptr=2, req=0011 -> requester 0 granted first, then 1.
REQ-037 req[1] dropped in ISSUE cycle -> done[1] still pulses, buffer receives the latched op exactly once.
REQ-038 rst asserted in CAPTURE -> no done pulse, all outputs at reset values, next grant to requester 0.
REQ-039 INCR on key 3 twice by requesters 0 and 2 -> buf_ctrl=INCR issued in two separate ISSUE cycles, never overlapped.
